// File: rtl/data_break_if.sv
// Bus between the RK8E data-break requester and the state machine, memory,
// IOT decoder and disk word buffer.
interface data_break_if;
   logic [4:0]  state;
   logic        break_in_prog;
   logic        ca_load;
   logic [11:0] ca_value;
   logic [2:0]  field_value;
   logic        wc_load;
   logic [11:0] wc_value;
   logic        go;
   logic        go_to_disk;
   logic        word_rdy;
   logic [11:0] disk_wdata;
   logic [11:0] mem_rdata;
   logic        word_ack;
   logic [11:0] disk_rdata;
   logic        data_break;
   logic        to_disk;
   logic [14:0] db_addr;
   logic [11:0] db_wdata;
   logic        db_mem_wr;
   logic        busy;
   logic        xfer_done;
   logic        wrap_err;

   modport master (
      input  state, break_in_prog, ca_load, ca_value, field_value, wc_load, wc_value,
             go, go_to_disk, word_rdy, disk_wdata, mem_rdata,
      output word_ack, disk_rdata, data_break, to_disk, db_addr, db_wdata, db_mem_wr,
             busy, xfer_done, wrap_err
   );

   modport slave (
      output state, break_in_prog, ca_load, ca_value, field_value, wc_load, wc_value,
             go, go_to_disk, word_rdy, disk_wdata, mem_rdata,
      input  word_ack, disk_rdata, data_break, to_disk, db_addr, db_wdata, db_mem_wr,
             busy, xfer_done, wrap_err
   );
endinterface

// File: rtl/data_break_ctrl.sv
// Single-cycle data-break requester for the RK8E: requests a stolen memory cycle
// per disk word, drives address/data during DB0-DB2 and steps CA/WC.
module data_break_ctrl #(
   parameter bit         CA_CARRY_FIELD = 1'b0,
   parameter bit         OVF_HALT       = 1'b1,
   parameter logic [4:0] ST_DB0         = 5'd12,
   parameter logic [4:0] ST_DB2         = 5'd14
) (
   input  logic          clk,
   input  logic          reset,
   data_break_if.master  bus
);

   localparam int unsigned AW = 12;
   localparam int unsigned FW = 3;

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_ARM    = 3'd1,
      S_REQ    = 3'd2,
      S_GRANT  = 3'd3,
      S_FINISH = 3'd4
   } fsm_e;

   fsm_e          fsm_q, fsm_d;
   logic [AW-1:0] ca_q, ca_d;
   logic [AW-1:0] wc_q, wc_d;
   logic [FW-1:0] field_q, field_d;
   logic [AW-1:0] db_wdata_q, db_wdata_d;
   logic [AW-1:0] disk_rdata_q, disk_rdata_d;
   logic          word_ack_q, word_ack_d;
   logic          data_break_q, data_break_d;
   logic          to_disk_q, to_disk_d;
   logic          db_mem_wr_q, db_mem_wr_d;
   logic          busy_q, busy_d;
   logic          xfer_done_q, xfer_done_d;
   logic          wrap_err_q, wrap_err_d;

   logic [AW-1:0] ca_inc;
   logic [AW-1:0] wc_inc;

   assign ca_inc = ca_q + AW'(1);
   assign wc_inc = wc_q + AW'(1);

   // Next-state and output logic
   always_comb begin
      fsm_d        = fsm_q;
      ca_d         = ca_q;
      wc_d         = wc_q;
      field_d      = field_q;
      db_wdata_d   = db_wdata_q;
      disk_rdata_d = disk_rdata_q;
      to_disk_d    = to_disk_q;
      busy_d       = busy_q;
      wrap_err_d   = wrap_err_q;
      word_ack_d   = 1'b0;
      data_break_d = 1'b0;
      db_mem_wr_d  = 1'b0;
      xfer_done_d  = 1'b0;

      unique case (fsm_q)
         S_IDLE: begin
            if (bus.ca_load) begin
               ca_d    = bus.ca_value;
               field_d = bus.field_value;
            end
            if (bus.wc_load) begin
               wc_d = bus.wc_value;
            end
            if (bus.go) begin
               fsm_d      = S_ARM;
               busy_d     = 1'b1;
               to_disk_d  = bus.go_to_disk;
               wrap_err_d = 1'b0;
            end
         end

         S_ARM: begin
            if (bus.word_rdy) begin
               fsm_d = S_REQ;
               if (!to_disk_q) begin
                  db_wdata_d = bus.disk_wdata;
                  word_ack_d = 1'b1;
               end
            end
         end

         // The write strobe is launched at DB0 so it lands in the DB1 cycle that follows.
         S_REQ: begin
            if (bus.state == ST_DB0) begin
               fsm_d       = S_GRANT;
               db_mem_wr_d = !to_disk_q;
            end else begin
               data_break_d = 1'b1;
            end
         end

         S_GRANT: begin
            if (!bus.break_in_prog) begin
               fsm_d      = S_IDLE;
               busy_d     = 1'b0;
               wrap_err_d = 1'b1;
            end else if (bus.state == ST_DB2) begin
               fsm_d = S_FINISH;
               if (to_disk_q) begin
                  disk_rdata_d = bus.mem_rdata;
                  word_ack_d   = 1'b1;
               end
            end
         end

         S_FINISH: begin
            ca_d  = ca_inc;
            wc_d  = wc_inc;
            fsm_d = S_ARM;
            if (ca_q == 12'o7777) begin
               if (CA_CARRY_FIELD) begin
                  field_d = field_q + FW'(1);
               end else if (OVF_HALT) begin
                  wrap_err_d = 1'b1;
                  busy_d     = 1'b0;
                  fsm_d      = S_IDLE;
               end
            end
            if (wc_inc == '0) begin
               xfer_done_d = 1'b1;
               busy_d      = 1'b0;
               fsm_d       = S_IDLE;
            end
         end

         default: begin
            fsm_d = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         fsm_q        <= S_IDLE;
         ca_q         <= '0;
         wc_q         <= '0;
         field_q      <= '0;
         db_wdata_q   <= '0;
         disk_rdata_q <= '0;
         word_ack_q   <= 1'b0;
         data_break_q <= 1'b0;
         to_disk_q    <= 1'b0;
         db_mem_wr_q  <= 1'b0;
         busy_q       <= 1'b0;
         xfer_done_q  <= 1'b0;
         wrap_err_q   <= 1'b0;
      end else begin
         fsm_q        <= fsm_d;
         ca_q         <= ca_d;
         wc_q         <= wc_d;
         field_q      <= field_d;
         db_wdata_q   <= db_wdata_d;
         disk_rdata_q <= disk_rdata_d;
         word_ack_q   <= word_ack_d;
         data_break_q <= data_break_d;
         to_disk_q    <= to_disk_d;
         db_mem_wr_q  <= db_mem_wr_d;
         busy_q       <= busy_d;
         xfer_done_q  <= xfer_done_d;
         wrap_err_q   <= wrap_err_d;
      end
   end

   assign bus.word_ack   = word_ack_q;
   assign bus.disk_rdata = disk_rdata_q;
   assign bus.data_break = data_break_q;
   assign bus.to_disk    = to_disk_q;
   assign bus.db_addr    = {field_q, ca_q};
   assign bus.db_wdata   = db_wdata_q;
   assign bus.db_mem_wr  = db_mem_wr_q;
   assign bus.busy       = busy_q;
   assign bus.xfer_done  = xfer_done_q;
   assign bus.wrap_err   = wrap_err_q;

endmodule

// File: tb/tb_data_break_ctrl.sv
// Bench for data_break_ctrl: three parameter variants share one stimulus set; a
// state-machine/memory/disk-buffer model feeds the selected one, scoreboards check it.
module tb_data_break_ctrl;

   localparam logic [4:0] ST_RUN = 5'd0;
   localparam logic [4:0] ST_DB0 = 5'd12;
   localparam logic [4:0] ST_DB1 = 5'd13;
   localparam logic [4:0] ST_DB2 = 5'd14;

   logic        clk = 1'b0;
   logic        reset_n = 1'b0;
   logic [1:0]  sel = 2'd2;
   logic [4:0]  sm_state;
   logic        bip_kill = 1'b0;
   logic        ca_load = 1'b0, wc_load = 1'b0, go = 1'b0, go_to_disk = 1'b0;
   logic [11:0] ca_value = '0, wc_value = '0;
   logic [2:0]  field_value = '0;
   logic        rdy_en = 1'b1;
   logic        tdir = 1'b0;
   logic        word_rdy;
   logic [11:0] disk_wdata;
   logic [11:0] mem_rdata;
   logic [11:0] mem [32768];
   logic [11:0] warr [64];
   int          wptr = 0;
   int          wend = 0;
   int          done_cnt = 0;
   logic [27:0] obs_wr [$];
   logic [11:0] obs_rd [$];
   logic [27:0] exp_wr [$];
   logic [11:0] exp_rd [$];
   int          checks = 0;
   int          failures = 0;

   logic [2:0]  v_db, v_todisk, v_wr, v_busy, v_done, v_werr, v_ack;
   logic [14:0] v_addr [3];
   logic [11:0] v_wdata [3];
   logic [11:0] v_rdata [3];
   logic        o_data_break, o_to_disk, o_db_mem_wr, o_busy, o_xfer_done, o_wrap_err, o_word_ack;
   logic [14:0] o_db_addr;
   logic [11:0] o_db_wdata, o_disk_rdata;

   always #5 clk = ~clk;

   data_break_if ifs [3] ();

   // Variant 0: no carry, no halt; 1: carry into field; 2: default (halt on wrap)
   for (genvar g = 0; g < 3; g++) begin : g_dut
      assign ifs[g].state         = sm_state;
      assign ifs[g].break_in_prog = (sm_state == ST_DB0 || sm_state == ST_DB1 ||
                                     sm_state == ST_DB2) && !bip_kill;
      assign ifs[g].ca_load       = ca_load;
      assign ifs[g].ca_value      = ca_value;
      assign ifs[g].field_value   = field_value;
      assign ifs[g].wc_load       = wc_load;
      assign ifs[g].wc_value      = wc_value;
      assign ifs[g].go            = go;
      assign ifs[g].go_to_disk    = go_to_disk;
      assign ifs[g].word_rdy      = word_rdy;
      assign ifs[g].disk_wdata    = disk_wdata;
      assign ifs[g].mem_rdata     = mem_rdata;

      data_break_ctrl #(
         .CA_CARRY_FIELD (g == 1),
         .OVF_HALT       (g != 0),
         .ST_DB0         (ST_DB0),
         .ST_DB2         (ST_DB2)
      ) u_dut (
         .clk   (clk),
         .reset (reset_n),
         .bus   (ifs[g])
      );

      assign v_db[g]     = ifs[g].data_break;
      assign v_todisk[g] = ifs[g].to_disk;
      assign v_wr[g]     = ifs[g].db_mem_wr;
      assign v_busy[g]   = ifs[g].busy;
      assign v_done[g]   = ifs[g].xfer_done;
      assign v_werr[g]   = ifs[g].wrap_err;
      assign v_ack[g]    = ifs[g].word_ack;
      assign v_addr[g]   = ifs[g].db_addr;
      assign v_wdata[g]  = ifs[g].db_wdata;
      assign v_rdata[g]  = ifs[g].disk_rdata;
   end

   always_comb begin
      o_data_break = v_db[sel];
      o_to_disk    = v_todisk[sel];
      o_db_mem_wr  = v_wr[sel];
      o_busy       = v_busy[sel];
      o_xfer_done  = v_done[sel];
      o_wrap_err   = v_werr[sel];
      o_word_ack   = v_ack[sel];
      o_db_addr    = v_addr[sel];
      o_db_wdata   = v_wdata[sel];
      o_disk_rdata = v_rdata[sel];
   end

   assign mem_rdata  = mem[o_db_addr];
   assign word_rdy   = rdy_en && (tdir || (wptr < wend));
   assign disk_wdata = warr[wptr % 64];

   // State machine model: grants DB0-DB2 once per observed request
   always @(posedge clk or negedge reset_n) begin
      if (!reset_n) sm_state <= ST_RUN;
      else begin
         case (sm_state)
            ST_RUN:  if (o_data_break) sm_state <= ST_DB0;
            ST_DB0:  sm_state <= ST_DB1;
            ST_DB1:  sm_state <= ST_DB2;
            default: sm_state <= ST_RUN;
         endcase
      end
   end

   // Observed-event collector
   always @(negedge clk) begin
      if (reset_n) begin
         if (o_db_mem_wr) obs_wr.push_back({sm_state == ST_DB1, o_db_addr, o_db_wdata});
         if (o_word_ack) begin
            if (o_to_disk) obs_rd.push_back(o_disk_rdata);
            else           wptr <= wptr + 1;
         end
         if (o_xfer_done) done_cnt <= done_cnt + 1;
      end
   end

   task automatic do_reset();
      @(negedge clk); reset_n = 1'b0;
      repeat (2) @(negedge clk);
      reset_n = 1'b1;
      @(negedge clk);
   endtask

   task automatic load(input logic [11:0] ca, input logic [2:0] f, input logic [11:0] wc);
      @(negedge clk); ca_value = ca; field_value = f; ca_load = 1'b1;
      wc_value = wc; wc_load = 1'b1;
      @(negedge clk); ca_load = 1'b0; wc_load = 1'b0;
   endtask

   task automatic pulse_go(input logic dir);
      @(negedge clk); go_to_disk = dir; go = 1'b1;
      @(negedge clk); go = 1'b0;
   endtask

   task automatic add_word(input logic [11:0] w);
      warr[wend % 64] = w;
      wend++;
   endtask

   task automatic wait_idle(input string name);
      int n = 0;
      while (o_busy && n < 500) begin @(negedge clk); n++; end
      checks++;
      if (o_busy !== 1'b0) begin
         failures++; $display("FAIL %s_timeout: busy=%b required 0", name, o_busy);
      end
      @(negedge clk);
   endtask

   task automatic test_reset();
      sel = 2'd2;
      do_reset();
      checks++;
      if ({o_busy, o_data_break, o_to_disk, o_db_mem_wr, o_word_ack, o_xfer_done, o_wrap_err} !== 7'b0) begin
         failures++; $display("FAIL reset_flags: got %b required 0", {o_busy, o_data_break, o_to_disk,
                              o_db_mem_wr, o_word_ack, o_xfer_done, o_wrap_err});
      end
      checks++;
      if ({o_db_addr, o_db_wdata, o_disk_rdata} !== 39'b0) begin
         failures++; $display("FAIL reset_data: addr=%o wdata=%o rdata=%o required 0", o_db_addr, o_db_wdata, o_disk_rdata);
      end
   endtask

   task automatic test_write_dir0();
      int base, d0;
      sel = 2'd2; tdir = 1'b0; do_reset();
      wend = wptr;
      add_word(12'o1111); add_word(12'o2222); add_word(12'o3333);
      exp_wr.push_back({1'b1, 15'o10200, 12'o1111});
      exp_wr.push_back({1'b1, 15'o10201, 12'o2222});
      exp_wr.push_back({1'b1, 15'o10202, 12'o3333});
      load(12'o0200, 3'd1, 12'o7775);
      base = obs_wr.size(); d0 = done_cnt;
      pulse_go(1'b0);
      wait_idle("write");
      checks++;
      if (obs_wr.size() - base != 3) begin
         failures++; $display("FAIL write_count: got %0d required 3", obs_wr.size() - base);
      end
      for (int i = 0; i < 3; i++) begin
         logic [27:0] e = exp_wr.pop_front();
         checks++;
         if (base + i >= obs_wr.size() || obs_wr[base + i] !== e) begin
            failures++; $display("FAIL write_%0d: got %h required %h", i,
                                 (base + i < obs_wr.size()) ? obs_wr[base + i] : 28'hxxxxxxx, e);
         end
      end
      checks++;
      if (done_cnt - d0 != 1) begin
         failures++; $display("FAIL write_done: got %0d required 1", done_cnt - d0);
      end
      checks++;
      if (o_db_addr !== 15'o10203 || o_wrap_err !== 1'b0) begin
         failures++; $display("FAIL write_final: addr=%o werr=%b required 10203 0", o_db_addr, o_wrap_err);
      end
   endtask

   task automatic test_read_wrap_nohalt();
      int base, d0;
      sel = 2'd0; tdir = 1'b1; do_reset();
      mem[15'o07776] = 12'o4321; mem[15'o07777] = 12'o1234;
      exp_rd.push_back(12'o4321); exp_rd.push_back(12'o1234);
      load(12'o7776, 3'd0, 12'o7776);
      base = obs_rd.size(); d0 = done_cnt;
      pulse_go(1'b1);
      checks++;
      if (o_to_disk !== 1'b1) begin
         failures++; $display("FAIL read_dir: got %b required 1", o_to_disk);
      end
      wait_idle("read");
      for (int i = 0; i < 2; i++) begin
         logic [11:0] e = exp_rd.pop_front();
         checks++;
         if (base + i >= obs_rd.size() || obs_rd[base + i] !== e) begin
            failures++; $display("FAIL read_%0d: got %o required %o", i,
                                 (base + i < obs_rd.size()) ? obs_rd[base + i] : 12'hxxx, e);
         end
      end
      checks++;
      if (o_db_addr !== 15'o00000 || o_wrap_err !== 1'b0 || done_cnt - d0 != 1) begin
         failures++; $display("FAIL read_final: addr=%o werr=%b done=%0d required 0 0 1",
                              o_db_addr, o_wrap_err, done_cnt - d0);
      end
   endtask

   task automatic test_carry_field();
      int base, d0;
      logic [27:0] e;
      sel = 2'd1; tdir = 1'b0; do_reset();
      wend = wptr;
      add_word(12'o5555);
      exp_wr.push_back({1'b1, 15'o27777, 12'o5555});
      load(12'o7777, 3'd2, 12'o7777);
      base = obs_wr.size(); d0 = done_cnt;
      pulse_go(1'b0);
      wait_idle("carry");
      e = exp_wr.pop_front();
      checks++;
      if (obs_wr.size() != base + 1 || obs_wr[base] !== e) begin
         failures++; $display("FAIL carry_write: got %0d writes first %h required 1 %h",
                              obs_wr.size() - base, (base < obs_wr.size()) ? obs_wr[base] : 28'hxxxxxxx, e);
      end
      checks++;
      if (o_db_addr !== 15'o30000 || done_cnt - d0 != 1 || o_wrap_err !== 1'b0) begin
         failures++; $display("FAIL carry_final: addr=%o done=%0d werr=%b required 30000 1 0",
                              o_db_addr, done_cnt - d0, o_wrap_err);
      end
   endtask

   task automatic test_ovf_halt();
      int base, d0;
      logic [27:0] e;
      sel = 2'd2; tdir = 1'b0; do_reset();
      wend = wptr;
      add_word(12'o0101); add_word(12'o0202);
      exp_wr.push_back({1'b1, 15'o07777, 12'o0101});
      load(12'o7777, 3'd0, 12'o7776);
      base = obs_wr.size(); d0 = done_cnt;
      pulse_go(1'b0);
      wait_idle("ovf");
      wend = wptr;
      e = exp_wr.pop_front();
      checks++;
      if (obs_wr.size() != base + 1 || obs_wr[base] !== e) begin
         failures++; $display("FAIL ovf_write: got %0d writes required 1 (%h)", obs_wr.size() - base, e);
      end
      checks++;
      if (o_wrap_err !== 1'b1 || done_cnt != d0 || o_db_addr !== 15'o00000) begin
         failures++; $display("FAIL ovf_final: werr=%b done=%0d addr=%o required 1 0 0",
                              o_wrap_err, done_cnt - d0, o_db_addr);
      end
   endtask

   task automatic test_busy_ignore();
      int base;
      sel = 2'd2; tdir = 1'b1; rdy_en = 1'b0; do_reset();
      mem[15'o00100] = 12'o0777; mem[15'o00101] = 12'o0666;
      exp_rd.push_back(12'o0777); exp_rd.push_back(12'o0666);
      load(12'o0100, 3'd0, 12'o7776);
      base = obs_rd.size();
      pulse_go(1'b1);
      load(12'o0500, 3'd3, 12'o7000);
      pulse_go(1'b0);
      checks++;
      if (o_to_disk !== 1'b1 || o_db_addr !== 15'o00100 || o_busy !== 1'b1) begin
         failures++; $display("FAIL busy_ignore: dir=%b addr=%o busy=%b required 1 00100 1",
                              o_to_disk, o_db_addr, o_busy);
      end
      rdy_en = 1'b1;
      wait_idle("busy");
      for (int i = 0; i < 2; i++) begin
         logic [11:0] e = exp_rd.pop_front();
         checks++;
         if (base + i >= obs_rd.size() || obs_rd[base + i] !== e) begin
            failures++; $display("FAIL busy_read_%0d: got %o required %o", i,
                                 (base + i < obs_rd.size()) ? obs_rd[base + i] : 12'hxxx, e);
         end
      end
      checks++;
      if (o_db_addr !== 15'o00102) begin
         failures++; $display("FAIL busy_final_addr: got %o required 00102", o_db_addr);
      end
   endtask

   task automatic test_word_rdy_wait();
      int base, k;
      logic seen = 1'b0;
      logic [27:0] e;
      sel = 2'd2; tdir = 1'b0; rdy_en = 1'b0; do_reset();
      wend = wptr;
      add_word(12'o0707);
      exp_wr.push_back({1'b1, 15'o00300, 12'o0707});
      load(12'o0300, 3'd0, 12'o7777);
      base = obs_wr.size();
      pulse_go(1'b0);
      for (int i = 0; i < 50; i++) begin
         @(negedge clk);
         if (o_data_break !== 1'b0) seen = 1'b1;
      end
      checks++;
      if (seen !== 1'b0) begin
         failures++; $display("FAIL idle_no_req: data_break seen=%b required 0", seen);
      end
      rdy_en = 1'b1;
      k = 0;
      while (k < 10) begin
         @(negedge clk); k++;
         if (o_data_break === 1'b1) break;
      end
      checks++;
      if (k != 2) begin
         failures++; $display("FAIL req_latency: got %0d clocks required 2", k);
      end
      wait_idle("rdy");
      e = exp_wr.pop_front();
      checks++;
      if (obs_wr.size() != base + 1 || obs_wr[base] !== e) begin
         failures++; $display("FAIL rdy_write: got %0d writes required 1 (%h)", obs_wr.size() - base, e);
      end
   endtask

   task automatic test_reset_mid_break();
      int base, k;
      sel = 2'd2; tdir = 1'b0; do_reset();
      wend = wptr;
      add_word(12'o1212);
      load(12'o0400, 3'd0, 12'o7777);
      pulse_go(1'b0);
      k = 0;
      while (o_data_break !== 1'b1 && k < 20) begin @(negedge clk); k++; end
      checks++;
      if (o_data_break !== 1'b1) begin
         failures++; $display("FAIL mid_req: data_break=%b required 1", o_data_break);
      end
      base = obs_wr.size();
      #2 reset_n = 1'b0;
      #1;
      checks++;
      if (o_data_break !== 1'b0 || o_busy !== 1'b0) begin
         failures++; $display("FAIL mid_reset: data_break=%b busy=%b required 0 0", o_data_break, o_busy);
      end
      repeat (3) @(negedge clk);
      reset_n = 1'b1;
      wend = wptr;
      repeat (5) @(negedge clk);
      checks++;
      if (obs_wr.size() != base) begin
         failures++; $display("FAIL mid_no_write: got %0d writes required 0", obs_wr.size() - base);
      end
   endtask

   task automatic test_abort();
      int d0;
      sel = 2'd2; tdir = 1'b0; bip_kill = 1'b1; do_reset();
      wend = wptr;
      add_word(12'o4444); add_word(12'o4445);
      load(12'o0600, 3'd0, 12'o7776);
      d0 = done_cnt;
      pulse_go(1'b0);
      wait_idle("abort");
      bip_kill = 1'b0;
      wend = wptr;
      checks++;
      if (o_wrap_err !== 1'b1 || done_cnt != d0 || o_db_addr !== 15'o00600) begin
         failures++; $display("FAIL abort: werr=%b done=%0d addr=%o required 1 0 00600",
                              o_wrap_err, done_cnt - d0, o_db_addr);
      end
   endtask

   initial begin
      test_reset();
      test_write_dir0();
      test_read_wrap_nohalt();
      test_carry_field();
      test_ovf_halt();
      test_busy_ignore();
      test_word_rdy_wait();
      test_reset_mid_break();
      test_abort();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
